sar_adc_seq: RTL and testbench

Digital sequencer directly upstream of the comparator/mux/sample-hold/DAC analog macro. It scans a latched mask of analog channels in ascending index order. For each channel it runs a non-overlapped S/H reset, sample, hold sequence, then a 10-bit successive-approximation search on `dac_code` using the macro's comparator output. It delivers one result per channel with a `done` pulse.

---
 rtl/sar_adc_pkg.sv | 32 +++
 rtl/sar_adc_seq_if.sv | 34 +++
 rtl/sar_chnl_pick.sv | 19 +
 rtl/sar_adc_seq.sv | 206 ++++++++++++++++++++
 tb/tb_sar_adc_seq.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types, default timing and helpers for the SAR ADC channel sequencer.
package sar_adc_pkg;

    localparam int CODE_W     = 10;
    localparam int N_CHNL_DEF = 14;
    localparam int T_RST_DEF  = 4;
    localparam int T_GAP_DEF  = 1;
    localparam int T_SMP_DEF  = 16;
    localparam int T_SET_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_GAP1,
        ST_SMP,
        ST_GAP2,
        ST_CONV,
        ST_DONE
    } sar_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sar_adc_seq_if.sv
// Control, result and analog-macro signals of the SAR ADC sequencer.
interface sar_adc_seq_if #(
    parameter int N_CHNL = sar_adc_pkg::N_CHNL_DEF
);
    import sar_adc_pkg::*;

    localparam int IDX_W = bits_for(N_CHNL);

    logic              start;
    logic              stop;
    logic [N_CHNL-1:0] chnl_msk;
    logic              busy;
    logic              done;
    logic [CODE_W-1:0] result;
    logic [IDX_W-1:0]  res_chnl;
    logic [N_CHNL-1:0] dac_sel;
    logic              sh_rst;
    logic              sh_hold;
    logic [CODE_W-1:0] dac_code;
    logic              comp_i;

    // Host plus analog macro side.
    modport master (
        output start, stop, chnl_msk, comp_i,
        input  busy, done, result, res_chnl, dac_sel, sh_rst, sh_hold, dac_code
    );

    // Sequencer side.
    modport slave (
        input  start, stop, chnl_msk, comp_i,
        output busy, done, result, res_chnl, dac_sel, sh_rst, sh_hold, dac_code
    );

endinterface

// File: rtl/sar_chnl_pick.sv
// Lowest-set-bit finder used to step through the channel mask in ascending order.
module sar_chnl_pick import sar_adc_pkg::*; #(
    parameter  int N_CHNL = N_CHNL_DEF,
    localparam int IDX_W  = bits_for(N_CHNL)
) (
    input  logic [N_CHNL-1:0] msk_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              none_o
);

    always_comb begin
        idx_o  = '0;
        none_o = ~|msk_i;
        for (int i = N_CHNL - 1; i >= 0; i--) begin
            if (msk_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/sar_adc_seq.sv
// Channel-scanning sequencer: S/H reset, sample, hold, then a 10-bit SAR search per channel.
module sar_adc_seq import sar_adc_pkg::*; #(
    parameter int N_CHNL = N_CHNL_DEF,
    parameter int T_RST  = T_RST_DEF,
    parameter int T_GAP  = T_GAP_DEF,
    parameter int T_SMP  = T_SMP_DEF,
    parameter int T_SET  = T_SET_DEF
) (
    input logic          clk,
    input logic          srst,
    sar_adc_seq_if.slave bus
);

    localparam int IDX_W = bits_for(N_CHNL);
    localparam int CNT_W = bits_for(max3(max3(T_RST, T_SMP, T_SET), T_GAP, 1));

    localparam logic [CNT_W-1:0] LD_RST = CNT_W'(T_RST - 1);
    localparam logic [CNT_W-1:0] LD_GAP = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] LD_SMP = CNT_W'(T_SMP - 1);
    localparam logic [CNT_W-1:0] LD_SET = CNT_W'(T_SET - 1);
    localparam logic [3:0]       MSB    = 4'(CODE_W - 1);

    sar_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [N_CHNL-1:0] msk_q, msk_d;
    logic              sync1_q, sync2_q;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CODE_W-1:0] result_q, result_d;
    logic [IDX_W-1:0]  res_chnl_q, res_chnl_d;
    logic [N_CHNL-1:0] dac_sel_q, dac_sel_d;
    logic              sh_rst_q, sh_rst_d;
    logic              sh_hold_q, sh_hold_d;
    logic [CODE_W-1:0] dac_code_q, dac_code_d;

    logic [N_CHNL-1:0] pick_msk;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_none;
    logic              cnt_zero;
    logic [CODE_W-1:0] code_dec;

    // In IDLE the first channel comes straight from the incoming mask.
    assign pick_msk = (state_q == ST_IDLE) ? bus.chnl_msk : msk_q;

    sar_chnl_pick #(.N_CHNL(N_CHNL)) u_pick (
        .msk_i  (pick_msk),
        .idx_o  (pick_idx),
        .none_o (pick_none)
    );

    assign cnt_zero = (cnt_q == '0);

    // Working code with the comparator decision for the current bit applied.
    always_comb begin
        code_dec = dac_code_q;
        if (!sync2_q) code_dec[bit_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            cur_q      <= '0;
            msk_q      <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            res_chnl_q <= '0;
            dac_sel_q  <= '0;
            sh_rst_q   <= 1'b0;
            sh_hold_q  <= 1'b1;
            dac_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            cur_q      <= cur_d;
            msk_q      <= msk_d;
            sync1_q    <= bus.comp_i;
            sync2_q    <= sync1_q;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            res_chnl_q <= res_chnl_d;
            dac_sel_q  <= dac_sel_d;
            sh_rst_q   <= sh_rst_d;
            sh_hold_q  <= sh_hold_d;
            dac_code_q <= dac_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        bit_d   = bit_q;
        cur_d   = cur_q;
        msk_d   = msk_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !pick_none) begin
                    msk_d   = bus.chnl_msk;
                    cur_d   = pick_idx;
                    cnt_d   = LD_RST;
                    state_d = ST_RST;
                end
            end
            ST_RST: begin
                if (cnt_zero) begin
                    cnt_d   = LD_GAP;
                    state_d = ST_GAP1;
                end
            end
            ST_GAP1: begin
                if (cnt_zero) begin
                    cnt_d   = LD_SMP;
                    state_d = ST_SMP;
                end
            end
            ST_SMP: begin
                if (cnt_zero) begin
                    cnt_d   = LD_GAP;
                    state_d = ST_GAP2;
                end
            end
            ST_GAP2: begin
                if (cnt_zero) begin
                    cnt_d   = LD_SET;
                    bit_d   = MSB;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (cnt_zero) begin
                    if (bit_q == '0) begin
                        msk_d[cur_q] = 1'b0;
                        state_d      = ST_DONE;
                    end else begin
                        bit_d = bit_q - 1'b1;
                        cnt_d = LD_SET;
                    end
                end
            end
            ST_DONE: begin
                // Lower bits are already cleared, so the lowest set bit is the next channel up.
                if (pick_none) begin
                    state_d = ST_IDLE;
                end else begin
                    cur_d   = pick_idx;
                    cnt_d   = LD_RST;
                    state_d = ST_RST;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            cur_d   = '0;
            msk_d   = '0;
        end
    end

    // Outputs are registered from the next state so every analog control is glitch-free.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        sh_rst_d  = (state_d == ST_RST);
        sh_hold_d = (state_d != ST_SMP);
        dac_sel_d = '0;
        if (state_d == ST_SMP) dac_sel_d[cur_d] = 1'b1;
        dac_code_d = '0;
        if (state_d == ST_CONV) begin
            if (state_q != ST_CONV) begin
                dac_code_d[MSB] = 1'b1;
            end else if (cnt_zero) begin
                dac_code_d        = code_dec;
                dac_code_d[bit_d] = 1'b1;
            end else begin
                dac_code_d = dac_code_q;
            end
        end
        result_d   = result_q;
        res_chnl_d = res_chnl_q;
        if (state_d == ST_DONE) begin
            result_d   = code_dec;
            res_chnl_d = cur_q;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.res_chnl = res_chnl_q;
    assign bus.dac_sel  = dac_sel_q;
    assign bus.sh_rst   = sh_rst_q;
    assign bus.sh_hold  = sh_hold_q;
    assign bus.dac_code = dac_code_q;

endmodule

// File: tb/tb_sar_adc_seq.sv
// Randomized bench for sar_adc_seq with a 2 mV/LSB behavioural S/H + comparator macro.
module tb_sar_adc_seq;
    import sar_adc_pkg::*;

    localparam int N      = 14;
    localparam int PERIOD = 4 + 2 * 1 + 16 + 10 * 16 + 1;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    sar_adc_seq_if #(.N_CHNL(N)) bus ();

    sar_adc_seq #(
        .N_CHNL (N),
        .T_RST  (4),
        .T_GAP  (1),
        .T_SMP  (16),
        .T_SET  (16)
    ) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int edge_cnt = 0;
    int vin [N];
    int samp_mv = 0;
    int exp_ch [$];
    int exp_res [$];
    int start_e = 0;
    int prev_done_e = 0;
    bit first_done = 1'b0;
    int last_res = 0;
    int viol_oh = 0;
    int viol_rst = 0;
    int viol_gap = 0;
    int last_rst_e = -100;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Largest code whose DAC level (2 mV/LSB) lies strictly below the input, clamped to 10 bits.
    function automatic int exp_code(input int mv);
        int c;
        if (mv <= 0) return 0;
        c = (mv - 1) / 2;
        return (c > 1023) ? 1023 : c;
    endfunction

    // Analog macro: S/H cap discharged by sh_rst, tracks the selected channel while sh_hold is low.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (bus.sh_rst) begin
            samp_mv <= 0;
        end else if (!bus.sh_hold) begin
            for (int i = 0; i < N; i++) begin
                if (bus.dac_sel[i]) samp_mv <= vin[i];
            end
        end
    end

    assign bus.comp_i = (samp_mv > 2 * int'(bus.dac_code));

    // Result scoreboard and analog-overlap monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!$onehot0(bus.dac_sel)) viol_oh++;
            if (bus.sh_rst && ((|bus.dac_sel) || !bus.sh_hold)) viol_rst++;
            if (bus.sh_rst) last_rst_e = edge_cnt;
            if (!bus.sh_hold && (edge_cnt - last_rst_e <= 1)) viol_gap++;
            if (bus.done) begin
                if (exp_ch.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    int ech;
                    int eres;
                    ech  = exp_ch.pop_front();
                    eres = exp_res.pop_front();
                    chk("res_chnl", int'(bus.res_chnl), ech);
                    chk("result", int'(bus.result), eres);
                    if (first_done) chk("first_latency", edge_cnt - start_e, PERIOD - 1);
                    else            chk("done_spacing", edge_cnt - prev_done_e, PERIOD);
                    first_done  = 1'b0;
                    prev_done_e = edge_cnt;
                    last_res    = eres;
                end
            end
        end
    end

    task automatic start_scan(input logic [N-1:0] m);
        @(negedge clk);
        bus.chnl_msk = m;
        bus.start    = 1'b1;
        start_e      = edge_cnt + 1;
        first_done   = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                exp_ch.push_back(i);
                exp_res.push_back(exp_code(vin[i]));
            end
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.chnl_msk = N'($urandom);
    endtask

    task automatic wait_scan(input int bound, input bit poke);
        int i;
        i = 0;
        while (bus.busy && i < bound) begin
            @(negedge clk);
            i++;
            if (poke) begin
                if (i == 250 && bus.busy) begin
                    bus.start    = 1'b1;
                    bus.chnl_msk = N'($urandom);
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        if (bus.busy) begin
            chk("scan_timeout", 1, 0);
        end else begin
            chk("busy_fall", edge_cnt - prev_done_e, 1);
            chk("pending_results", exp_ch.size(), 0);
        end
    endtask

    task automatic chk_reset(input string p, input int res_exp);
        chk({p, "busy"},     int'(bus.busy),     0);
        chk({p, "done"},     int'(bus.done),     0);
        chk({p, "result"},   int'(bus.result),   res_exp);
        chk({p, "res_chnl"}, int'(bus.res_chnl), 0);
        chk({p, "dac_sel"},  int'(bus.dac_sel),  0);
        chk({p, "sh_rst"},   int'(bus.sh_rst),   0);
        chk({p, "sh_hold"},  int'(bus.sh_hold),  1);
        chk({p, "dac_code"}, int'(bus.dac_code), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int quiet;
        int i;
        logic [N-1:0] m;

        srst         = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.chnl_msk = '0;
        for (int k = 0; k < N; k++) vin[k] = 0;
        repeat (3) @(negedge clk);
        chk_reset("rst_", 0);
        srst = 1'b0;

        vin[0] = 1000;
        start_scan(14'h0001);
        wait_scan(400, 1'b0);
        chk("single_hold_result", int'(bus.result), 499);

        vin[0] = 100; vin[2] = 2000; vin[13] = 0;
        start_scan(14'h2005);
        wait_scan(800, 1'b0);

        @(negedge clk);
        bus.chnl_msk = '0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("zero_msk_busy", int'(bus.busy), 0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy || bus.done || bus.sh_rst || !bus.sh_hold || (bus.dac_sel != '0)) quiet++;
        end
        chk("zero_msk_quiet", quiet, 0);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) vin[k] = int'($urandom_range(0, 2200));
            m = N'($urandom);
            if (r == 0) m = '1;
            if (m == '0) m = 14'h0001;
            start_scan(m);
            wait_scan(N * PERIOD + 50, 1'b1);
        end

        vin[4] = 1234;
        start_scan(14'h0010);
        wait_scan(400, 1'b0);

        vin[3] = 700;
        start_scan(14'h0008);
        while (edge_cnt < start_e + 89) @(negedge clk);
        chk("stop_in_bit5", int'(bus.dac_code[5]), 1);
        exp_ch.delete();
        exp_res.delete();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_busy",     int'(bus.busy),     0);
        chk("stop_dac_code", int'(bus.dac_code), 0);
        chk("stop_sh_hold",  int'(bus.sh_hold),  1);
        chk("stop_dac_sel",  int'(bus.dac_sel),  0);
        chk("stop_result",   int'(bus.result),   last_res);
        chk("stop_res_chnl", int'(bus.res_chnl), 4);
        repeat (200) @(negedge clk);
        chk("stop_stays_idle", int'(bus.busy), 0);

        vin[1] = 1500;
        start_scan(14'h0002);
        i = 0;
        while (bus.sh_hold && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("srst_in_smp", int'(bus.sh_hold), 0);
        exp_ch.delete();
        exp_res.delete();
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk_reset("srst_", 0);
        last_res = 0;

        for (int k = 0; k < N; k++) vin[k] = int'($urandom_range(0, 2200));
        start_scan(14'h0402);
        wait_scan(2 * PERIOD + 50, 1'b0);

        chk("dac_sel_onehot0", viol_oh, 0);
        chk("sh_rst_overlap", viol_rst, 0);
        chk("rst_to_track_gap", viol_gap, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
